// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: state encoding,
// data width and idle line level.
package uart_pkg;

    localparam int   UART_DATA_W    = 8;
    localparam logic UART_LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with registered count; full/empty decode from the count.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte queue feeding an 8N1 serializer, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low)
// DATA   | data bits 0..7, LSB first
// PARITY | even parity of the byte (UART_TX_PARITY_EN only)
// STOP   | stop bit (high); pops the next byte directly into START
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] data,
    input  logic                   write_en,
    output logic                   full,
    output logic                   rdy,
    output logic                   tx
);

    localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_W - 1);

    uart_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   bit_end;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FCNT_W-1:0]      fifo_count;
    logic [UART_DATA_W-1:0] fifo_rd_data;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (write_en),
        .wr_data (data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // With CLKS_PER_BIT=1 CNT_MAX is 0, so every state lasts exactly one cycle.
    assign bit_end = (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= UART_LINE_IDLE;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_rd_data;
`endif
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Chain straight into the next frame so queued bytes leave gap-free.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_rd_data;
`endif
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        tx_d = UART_LINE_IDLE;
        rdy  = (state_q == ST_IDLE) && (fifo_count == '0);
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_q;
`endif
            default:   tx_d = UART_LINE_IDLE;
        endcase
    end

    assign full = fifo_full;
    assign tx   = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: one instance at 1 clock/bit with a frame-decoding
// scoreboard monitor, one at 4 clocks/bit checked bit-period by bit-period.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data1, data4;
    logic       we1, we4;
    logic       full1, rdy1, tx1;
    logic       full4, rdy4, tx4;

    int         total = 0;
    int         bad = 0;
    int         frames_rx = 0;
    logic [7:0] exp_q1 [$];

    uart_tx_fifo #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .data(data1), .write_en(we1),
        .full(full1), .rdy(rdy1), .tx(tx1)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .data(data4), .write_en(we4),
        .full(full4), .rdy(rdy4), .tx(tx4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: decodes each frame on tx1 and compares to the queue.
    initial begin : monitor
        logic [7:0] got;
        logic       par;
        logic       stop;
        logic       abort;
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx1 === 1'b0) begin
                abort = 1'b0;
                par   = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    got[i] = tx1;
                    abort |= !rst_n;
                end
`ifdef UART_TX_PARITY_EN
                @(negedge clk);
                par = tx1;
                abort |= !rst_n;
`endif
                @(negedge clk);
                stop = tx1;
                abort |= !rst_n;
                if (!abort) begin
                    frames_rx++;
                    if (exp_q1.size() == 0) begin
                        chk("rx_unexpected_frame", {24'd0, got}, 32'hFFFF_FFFF);
                    end else begin
                        exp = exp_q1.pop_front();
                        chk("rx_byte", {24'd0, got}, {24'd0, exp});
                        chk("rx_stop", {31'd0, stop}, 32'd1);
`ifdef UART_TX_PARITY_EN
                        chk("rx_parity", {31'd0, par}, {31'd0, ^exp});
`endif
                    end
                end
            end
        end
    end

    task automatic push1(input logic [7:0] b, input bit accepted);
        @(negedge clk);
        data1 = b;
        we1   = 1'b1;
        if (accepted) exp_q1.push_back(b);
    endtask

    task automatic end_push1();
        @(posedge clk);
        #1 we1 = 1'b0;
    endtask

    // Starts at the negedge where the start bit is expected.
    task automatic expect_frame1(input logic [7:0] b, input bit last);
        @(negedge clk);
        chk("f1_start", {31'd0, tx1}, 32'd0);
        chk("f1_rdy_start", {31'd0, rdy1}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("f1_data", {31'd0, tx1}, {31'd0, b[i]});
            chk("f1_rdy_data", {31'd0, rdy1}, 32'd0);
        end
`ifdef UART_TX_PARITY_EN
        @(negedge clk);
        chk("f1_parity", {31'd0, tx1}, {31'd0, ^b});
`endif
        @(negedge clk);
        chk("f1_stop", {31'd0, tx1}, 32'd1);
        chk("f1_rdy_stop", {31'd0, rdy1}, 32'd0);
        if (last) begin
            @(negedge clk);
            chk("f1_rdy_after", {31'd0, rdy1}, 32'd1);
            chk("f1_idle_after", {31'd0, tx1}, 32'd1);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int         fr0;
        bit         found;
        logic [7:0] b4;
        logic [10:0] fb;

        rst_n = 1'b0;
        we1 = 1'b0; we4 = 1'b0;
        data1 = 8'h00; data4 = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx1}, 32'd1);
        chk("rst_rdy", {31'd0, rdy1}, 32'd1);
        chk("rst_full", {31'd0, full1}, 32'd0);
        chk("rst_tx4", {31'd0, tx4}, 32'd1);
        chk("rst_rdy4", {31'd0, rdy4}, 32'd1);
        chk("rst_full4", {31'd0, full4}, 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_tx", {31'd0, tx1}, 32'd1);
            chk("idle_rdy", {31'd0, rdy1}, 32'd1);
            chk("idle_full", {31'd0, full1}, 32'd0);
        end

        // Single byte 0x55: tx low after edge k+1, rdy low from edge k
        push1(8'h55, 1'b1);
        end_push1();
        @(negedge clk);
        chk("latency_rdy_low", {31'd0, rdy1}, 32'd0);
        chk("latency_tx_still_idle", {31'd0, tx1}, 32'd1);
        expect_frame1(8'h55, 1'b1);

        // Back-to-back 0xA5, 0x3C: contiguous frames
        repeat (3) @(negedge clk);
        push1(8'hA5, 1'b1);
        push1(8'h3C, 1'b1);
        end_push1();
        expect_frame1(8'hA5, 1'b0);
        expect_frame1(8'h3C, 1'b1);

        // Overflow: 0x01..0x06 on six edges, 0x06 dropped
        repeat (3) @(negedge clk);
        fr0 = frames_rx;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 5) chk("full_after4", {31'd0, full1}, 32'd0);
            if (i == 6) chk("full_after5", {31'd0, full1}, 32'd1);
            data1 = 8'(i);
            we1   = 1'b1;
            if (i <= 5) exp_q1.push_back(8'(i));
        end
        end_push1();
        @(negedge clk);
        chk("full_after6", {31'd0, full1}, 32'd1);
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (!full1) found = 1'b1;
        end
        chk("full_clear_seen", {31'd0, found}, 32'd1);
        chk("full_clear_tx_start", {31'd0, tx1}, 32'd0);
        chk("full_clear_frames_done", frames_rx - fr0, 32'd1);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (rdy1) found = 1'b1;
        end
        chk("overflow_drain_seen", {31'd0, found}, 32'd1);
        chk("overflow_frames", frames_rx - fr0, 32'd5);
        chk("overflow_queue_empty", exp_q1.size(), 32'd0);

        // CLKS_PER_BIT=4: each bit held four cycles
`ifdef UART_TX_PARITY_EN
        b4 = 8'h07;
        fb = {1'b1, 1'b1, b4, 1'b0};
`else
        b4 = 8'h80;
        fb = {1'b1, 1'b1, b4, 1'b0};
`endif
        @(negedge clk);
        data4 = b4;
        we4   = 1'b1;
        @(posedge clk);
        #1 we4 = 1'b0;
        @(negedge clk);
        chk("cpb4_rdy_low", {31'd0, rdy4}, 32'd0);
        chk("cpb4_tx_pre", {31'd0, tx4}, 32'd1);
        for (int c = 0; c < NB * 4; c++) begin
            @(negedge clk);
            chk("cpb4_bit", {31'd0, tx4}, {31'd0, fb[c / 4]});
            chk("cpb4_rdy_busy", {31'd0, rdy4}, 32'd0);
        end
        @(negedge clk);
        chk("cpb4_rdy_after", {31'd0, rdy4}, 32'd1);
        chk("cpb4_idle_after", {31'd0, tx4}, 32'd1);

        // Reset during data bit 3 of the first of two queued bytes
        repeat (3) @(negedge clk);
        fr0 = frames_rx;
        push1(8'hF0, 1'b1);
        push1(8'h0F, 1'b1);
        end_push1();
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_bit3", {31'd0, tx1}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("reset_async_tx", {31'd0, tx1}, 32'd1);
        chk("reset_async_rdy", {31'd0, rdy1}, 32'd1);
        chk("reset_async_full", {31'd0, full1}, 32'd0);
        exp_q1.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            chk("post_reset_tx", {31'd0, tx1}, 32'd1);
            chk("post_reset_rdy", {31'd0, rdy1}, 32'd1);
        end
        chk("post_reset_no_frames", frames_rx - fr0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
